// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one up-counter among NREQ requesters.
// Define COUNT_ARB_ABORT_EN to end a run early when the winner drops req.
module count_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tc,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      cnt,
  output logic                  busy
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     w_win;
  logic              w_any;
  logic [WIDTH-1:0]  r_tc;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  w_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   w_gnt;
  logic [NREQ-1:0]   w_done;
  logic [NREQ-1:0]   w_oh_new;
  logic [NREQ-1:0]   w_oh_cur;
  logic              r_busy;
  logic              w_busy;

  // Walk downward so the nearest set bit after r_last wins.
  always_comb begin : pick
    logic [IW-1:0] j;
    j     = '0;
    w_any = 1'b0;
    w_win = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      j = IW'((int'(r_last) + i) % NREQ);
      if (req[j]) begin
        w_any = 1'b1;
        w_win = j;
      end
    end
  end

  assign w_oh_new = NREQ'(1) << w_win;
  assign w_oh_cur = NREQ'(1) << r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_RUN;
      S_RUN: begin
`ifdef COUNT_ARB_ABORT_EN
        if (!req[r_last])       w_next = S_IDLE;
        else if (r_cnt == r_tc) w_next = S_DONE;
`else
        if (r_cnt == r_tc) w_next = S_DONE;
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt  = '0;
    w_done = '0;
    w_cnt  = '0;
    w_busy = 1'b0;
    case (w_next)
      S_RUN: begin
        w_busy = 1'b1;
        if (r_state == S_IDLE) begin
          w_gnt = w_oh_new;
        end else begin
          w_gnt = r_gnt;
          w_cnt = r_cnt + WIDTH'(1);
        end
      end
      S_DONE: begin
        w_done = w_oh_cur;
        w_cnt  = r_cnt;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= IW'(NREQ - 1);
      r_tc   <= '0;
      r_cnt  <= '0;
      r_gnt  <= '0;
      r_done <= '0;
      r_busy <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_last <= w_win;
        r_tc   <= tc[w_win*WIDTH +: WIDTH];
      end
      r_cnt  <= w_cnt;
      r_gnt  <= w_gnt;
      r_done <= w_done;
      r_busy <= w_busy;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter (NREQ=4, WIDTH=4).
// Expected per-cycle outputs are queued at stimulus time.
module tb_count_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] tc;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  cnt;
  logic        busy;

  int n_chk;
  int n_err;
  logic [31:0] q[$];

  count_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .tc   (tc),
    .gnt  (gnt),
    .done (done),
    .cnt  (cnt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [3:0] g,
                                       input logic [3:0] d,
                                       input logic [3:0] c,
                                       input logic b);
    return {19'd0, g, d, c, b};
  endfunction

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  task automatic push_round(input int w, input int tcv);
    for (int k = 0; k <= tcv; k++)
      q.push_back(pack(oh(w), 4'd0, 4'(k), 1'b1));
    q.push_back(pack(4'd0, oh(w), 4'(tcv), 1'b1));
    q.push_back(pack(4'd0, 4'd0, 4'd0, 1'b0));
  endtask

  task automatic round(input logic [3:0] rv, input int w,
                       input int tcv, input bit drop,
                       input bit scr);
    req = rv;
    push_round(w, tcv);
    for (int k = 1; k <= tcv + 3; k++) begin
      @(negedge clk);
      if (k == 1 && scr) tc = ~tc;
      if (k == tcv + 2 && drop) req = 4'd0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && q.size() > 0)
      chk("out", pack(gnt, done, cnt, busy), q.pop_front());
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    req = 4'd0;
    tc  = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst", pack(gnt, done, cnt, busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle", pack(gnt, done, cnt, busy), 32'd0);

    tc = 16'h1111;
    for (int r = 0; r < 5; r++)
      round(4'hF, r % 4, 1, r == 4, 1'b0);

    tc[3:0] = 4'd3;
    round(4'b0001, 0, 3, 1'b1, 1'b0);

    tc[11:8] = 4'd0;
    round(4'b0100, 2, 0, 1'b1, 1'b0);

    tc[7:4] = 4'd15;
    round(4'b0010, 1, 15, 1'b1, 1'b1);

    tc[11:8] = 4'd5;
    req = 4'b0100;
`ifdef COUNT_ARB_ABORT_EN
    q.push_back(pack(4'b0100, 4'd0, 4'd0, 1'b1));
    q.push_back(pack(4'b0100, 4'd0, 4'd1, 1'b1));
    q.push_back(pack(4'd0, 4'd0, 4'd0, 1'b0));
    repeat (2) @(negedge clk);
    req = 4'd0;
    repeat (2) @(negedge clk);
`else
    push_round(2, 5);
    repeat (2) @(negedge clk);
    req = 4'd0;
    repeat (6) @(negedge clk);
`endif

    tc[11:8] = 4'd5;
    tc[3:0]  = 4'd2;
    req = 4'b0100;
    q.push_back(pack(4'b0100, 4'd0, 4'd0, 1'b1));
    q.push_back(pack(4'b0100, 4'd0, 4'd1, 1'b1));
    q.push_back(pack(4'b0100, 4'd0, 4'd2, 1'b1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", 32'(q.size()), 32'd0);
    q.delete();
    req = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    round(4'hF, 0, 2, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    chk("end", pack(gnt, done, cnt, busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
